// File: rtl/bcd_conv_sched.sv
// Two-client round-robin scheduler feeding a serial double-dabble binary-to-BCD converter.
// Define BCD_SIGNED_EN to treat operands as two's complement (sign output + magnitude conversion).
module bcd_conv_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [15:0] bin0,
   input  logic [15:0] bin1,
   output logic [1:0]  gnt,
   output logic        busy,
   output logic        done,
   output logic        done_id,
   output logic [19:0] bcd,
   output logic        sign
);
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q;
   logic [19:0] work_q;
   logic [15:0] opnd_q;
   logic [3:0]  cnt_q;
   logic        last_q;
   logic        id_q;
   logic        neg_q;
   logic [1:0]  gnt_q;
   logic        busy_q;
   logic        done_q;
   logic        done_id_q;
   logic        sign_q;
   logic [19:0] bcd_q;

   logic        pick_d;
   logic [15:0] raw_d;
   logic [15:0] mag_d;
   logic        neg_d;
   logic [19:0] adj_d;
   logic [19:0] shift_d;
   logic        unused_adj_top;

   // With both clients requesting, serve the one that was not served last.
   always_comb begin
      if (req == 2'b11) pick_d = ~last_q;
      else              pick_d = req[1];
   end

   assign raw_d = pick_d ? bin1 : bin0;

`ifdef BCD_SIGNED_EN
   assign neg_d = raw_d[15];
   assign mag_d = raw_d[15] ? (~raw_d + 16'd1) : raw_d;
`else
   assign neg_d = 1'b0;
   assign mag_d = raw_d;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_dabble
         assign adj_d[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ? (work_q[4*gi +: 4] + 4'd3)
                                                               : work_q[4*gi +: 4];
      end
   endgenerate

   // The top bit falls off the shift; it is always zero for a 16-bit operand.
   assign shift_d        = {adj_d[18:0], opnd_q[15]};
   assign unused_adj_top = adj_d[19];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         work_q    <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         neg_q     <= 1'b0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req != 2'b00) begin
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
                  gnt_q   <= pick_d ? 2'b10 : 2'b01;
                  last_q  <= pick_d;
                  id_q    <= pick_d;
                  neg_q   <= neg_d;
                  opnd_q  <= mag_d;
                  work_q  <= '0;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               gnt_q  <= '0;
               work_q <= shift_d;
               opnd_q <= {opnd_q[14:0], 1'b0};
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  bcd_q     <= shift_d;
                  done_id_q <= id_q;
                  sign_q    <= neg_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign bcd     = bcd_q;
   assign sign    = sign_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: schedule-level reference model plus directed
// and randomized two-client traffic. Honors BCD_SIGNED_EN the same way as the design.
module tb_bcd_conv_sched;
   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [15:0] bin0;
   logic [15:0] bin1;
   logic [1:0]  gnt;
   logic        busy;
   logic        done;
   logic        done_id;
   logic [19:0] bcd;
   logic        sign;

   int n_cmp  = 0;
   int n_fail = 0;

   bcd_conv_sched dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .bin0    (bin0),
      .bin1    (bin1),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .bcd     (bcd),
      .sign    (sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decimal digits by plain division.
   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int mag_of(input logic [15:0] v);
`ifdef BCD_SIGNED_EN
      if (v[15]) return 65536 - int'(v);
`endif
      return int'(v);
   endfunction

   function automatic logic neg_of(input logic [15:0] v);
`ifdef BCD_SIGNED_EN
      return v[15];
`else
      return 1'b0 & v[15];
`endif
   endfunction

   function automatic logic rr_pick(input logic [1:0] r, input logic last);
      return (r == 2'b11) ? ~last : r[1];
   endfunction

   // Reference schedule: accept in idle, gnt 1 cycle later, done 17 cycles later, idle again after 18.
   logic [1:0]  e_gnt;
   logic        e_busy, e_done, e_id, e_sign;
   logic [19:0] e_bcd;
   logic        m_active, m_last, m_id, m_neg;
   logic [19:0] m_res;
   int          m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_gnt    <= 2'b00;
         e_busy   <= 1'b0;
         e_done   <= 1'b0;
         e_id     <= 1'b0;
         e_sign   <= 1'b0;
         e_bcd    <= '0;
         m_active <= 1'b0;
         m_last   <= 1'b1;
         m_id     <= 1'b0;
         m_neg    <= 1'b0;
         m_res    <= '0;
         m_cnt    <= 0;
      end else if (m_active) begin
         e_gnt <= 2'b00;
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == 16) begin
            e_done <= 1'b1;
            e_bcd  <= m_res;
            e_id   <= m_id;
            e_sign <= m_neg;
         end else begin
            e_done <= 1'b0;
         end
         if (m_cnt + 1 == 17) begin
            m_active <= 1'b0;
            e_busy   <= 1'b0;
         end
      end else if (req != 2'b00) begin
         m_active <= 1'b1;
         e_busy   <= 1'b1;
         m_cnt    <= 0;
         e_gnt    <= rr_pick(req, m_last) ? 2'b10 : 2'b01;
         m_last   <= rr_pick(req, m_last);
         m_id     <= rr_pick(req, m_last);
         m_res    <= to_bcd(mag_of(rr_pick(req, m_last) ? bin1 : bin0));
         m_neg    <= neg_of(rr_pick(req, m_last) ? bin1 : bin0);
      end
   end

   always @(negedge clk) begin
      chk("outputs{gnt,busy,done,id,sign,bcd}",
          {6'd0, gnt, busy, done, done_id, sign, bcd},
          {6'd0, e_gnt, e_busy, e_done, e_id, e_sign, e_bcd});
   end

   task automatic reset_pulse();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", {6'd0, gnt, busy, done, done_id, sign, bcd}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One conversion by client c; operand scrambled right after gnt.
   task automatic run_one(input int c, input logic [15:0] op, input logic [19:0] exp_bcd,
                          input logic exp_sign, input string name);
      int g_at;
      int d_at;
      g_at = -1;
      d_at = -1;
      if (c == 0) bin0 = op; else bin1 = op;
      req[c] = 1'b1;
      for (int n = 1; n <= 40 && d_at < 0; n++) begin
         @(negedge clk);
         if (done) begin
            d_at = n;
            chk({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
            chk({name, "_id"}, 32'(done_id), 32'(c));
            chk({name, "_sign"}, 32'(sign), 32'(exp_sign));
         end
         if (gnt[c] && g_at < 0) begin
            g_at = n;
            #1 req[c] = 1'b0;
            if (c == 0) bin0 = ~op; else bin1 = ~op;
         end
      end
      chk({name, "_gnt_latency"}, g_at, 1);
      chk({name, "_done_latency"}, d_at, 17);
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'd9999;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic [1:0]  g_seq [2];
      logic [19:0] d_bcd [2];
      logic        d_id  [2];
      int          ng, nd, t0, t1;

      rst_n = 1'b0;
      req   = 2'b00;
      bin0  = '0;
      bin1  = '0;

      chk("model_65535", 32'(to_bcd(65535)), 32'h65535);
      chk("model_9999", 32'(to_bcd(9999)), 32'h09999);
      chk("model_42", 32'(to_bcd(42)), 32'h00042);
`ifdef BCD_SIGNED_EN
      chk("model_mag_8000", mag_of(16'h8000), 32768);
      chk("model_mag_ffff", mag_of(16'hFFFF), 1);
`else
      chk("model_mag_ffff", mag_of(16'hFFFF), 65535);
`endif

      repeat (2) @(negedge clk);
      chk("reset_state", {6'd0, gnt, busy, done, done_id, sign, bcd}, 32'd0);
      #1 rst_n = 1'b1;

`ifdef BCD_SIGNED_EN
      run_one(0, 16'hFFFF, 20'h00001, 1'b1, "ffff_c0");
      run_one(0, 16'h8000, 20'h32768, 1'b1, "8000_c0");
`else
      run_one(0, 16'hFFFF, 20'h65535, 1'b0, "ffff_c0");
      run_one(0, 16'h8000, 20'h32768, 1'b0, "8000_c0");
`endif
      run_one(0, 16'd0, 20'h00000, 1'b0, "zero_c0");
      run_one(1, 16'd9999, 20'h09999, 1'b0, "9999_c1");

      // Simultaneous request straight out of reset: client 0 first.
      reset_pulse();
      bin0 = 16'd42;
      bin1 = 16'd1234;
      req  = 2'b11;
      ng = 0;
      nd = 0;
      for (int n = 0; n < 60 && nd < 2; n++) begin
         @(negedge clk);
         if (done) begin
            d_bcd[nd] = bcd;
            d_id[nd]  = done_id;
            nd++;
         end
         if (gnt != 2'b00 && ng < 2) begin
            g_seq[ng] = gnt;
            ng++;
            #1 req = req & ~gnt;
         end
      end
      chk("rr_gnt_count", ng, 2);
      chk("rr_done_count", nd, 2);
      if (ng == 2) begin
         chk("rr_gnt_first", 32'(g_seq[0]), 32'h1);
         chk("rr_gnt_second", 32'(g_seq[1]), 32'h2);
      end
      if (nd == 2) begin
         chk("rr_done0_bcd", 32'(d_bcd[0]), 32'h00042);
         chk("rr_done0_id", 32'(d_id[0]), 32'd0);
         chk("rr_done1_bcd", 32'(d_bcd[1]), 32'h01234);
         chk("rr_done1_id", 32'(d_id[1]), 32'd1);
      end
      repeat (3) @(negedge clk);
      #1;

      // Client 1 raises its request while client 0 is being served.
      bin0 = 16'd500;
      req  = 2'b01;
      t0 = -1;
      t1 = -1;
      for (int n = 0; n < 60 && t1 < 0; n++) begin
         @(negedge clk);
         if (gnt[0] && t0 < 0) begin
            t0 = n;
            #1 req = 2'b10;
            bin1 = 16'd777;
         end else if (gnt[1] && t0 >= 0) begin
            t1 = n;
            #1 req = 2'b00;
         end
      end
      chk("busy_hold_gnt_gap", t1 - t0, 18);
      repeat (20) @(negedge clk);
      #1;

      // Mid-conversion reset abandons the work; model checks for no done.
      req  = 2'b01;
      bin0 = 16'd321;
      repeat (5) @(negedge clk);
      reset_pulse();
      req = 2'b00;
      repeat (25) @(negedge clk);
      #1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 299) == 0) begin
            reset_pulse();
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (gnt[i]) begin
                  req[i] = ($urandom_range(0, 2) == 0);
                  if (i == 0) bin0 = rnd_op(); else bin1 = rnd_op();
               end else if (!req[i]) begin
                  if (i == 0) bin0 = rnd_op(); else bin1 = rnd_op();
                  if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
               end
            end
         end
      end
      req = 2'b00;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  2  per-client conversion request; client must hold req[i] and bin_i stable until gnt[i].
REQ-005 bin0  input  16  client 0 operand.
REQ-006 bin1  input  16  client 1 operand.
REQ-007 gnt  output  2  one-hot, one-cycle pulse: operand of that client captured.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 done  output  1  one-cycle pulse: bcd/done_id/sign valid.
REQ-010 done_id  output  1  client whose result is on bcd; held until next done.
REQ-011 bcd  output  20  {ten-thousands,thousands,hundreds,tens,ones}; held until next done.
REQ-012 sign  output  1  result negative (SIGNED_EN only; constant 0 otherwise).

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; IDLE->SHIFT on a clock edge with state IDLE and req!=0; SHIFT->DONE on the 16th SHIFT edge; DONE->IDLE unconditionally on the next edge.
REQ-014 Arbitration SHALL occur only on edges in IDLE; single requester is granted; with req=2'b11, the client not served last is granted (round-robin).
REQ-015 The last-served pointer SHALL reset to client 1, so client 0 wins the first simultaneous request.
REQ-016 On the accepting edge E0, the block SHALL capture the granted operand, clear the 20-bit working register and the 4-bit iteration counter, and assert gnt[i] for exactly the cycle after E0.
REQ-017 Each SHIFT edge SHALL perform one double-dabble iteration, MSB first: add 3 to every working nibble >=5, then shift left one bit, inserting the next operand bit.
REQ-018 On edge E16, bcd, done_id and sign SHALL be loaded; done SHALL be high for exactly the cycle after E16 (state DONE).
REQ-019 Latency SHALL be 17 clock edges from acceptance to done; the next request is sampled no earlier than E18 (one accept per 18 cycles max).
REQ-020 Requests arriving or changing while busy SHALL be ignored; operand changes after gnt SHALL NOT affect the result in progress.
REQ-021 Input 16'hFFFF SHALL yield bcd 20'h65535; no output digit SHALL exceed 9.
REQ-022 gnt and done SHALL never be high in the same cycle.

Reset
REQ-023 Asserting rst_n low SHALL asynchronously force state IDLE, gnt=0, busy=0, done=0, done_id=0, bcd=0, sign=0, counter=0, pointer=client 1.
REQ-024 Reset during SHIFT or DONE SHALL abandon the conversion with no done pulse; after release the block SHALL accept a new request on the first edge.

Configuration
REQ-025 Macro BCD_SIGNED_EN defined: bin0/bin1 SHALL be treated as two's complement; sign = operand bit 15; conversion SHALL use the 16-bit magnitude (16'h8000 -> 32768).
REQ-026 Macro BCD_SIGNED_EN undefined: operands SHALL be unsigned 0..65535 and sign SHALL be tied to 0.

Verification
REQ-027 Reset: rst_n low mid-run -> all outputs 0, busy 0 within the same cycle, no done.
REQ-028 req=01, bin0=16'hFFFF -> gnt=01 cycle after E0, done cycle after E16, bcd=20'h65535, done_id=0.
REQ-029 req=11, bin0=16'd42, bin1=16'd1234 from reset -> first done bcd=20'h00042 id 0, second done bcd=20'h01234 id 1; gnt pulses ordered 01 then 10.
REQ-030 bin0=0 -> bcd=20'h00000; bin1=16'd9999 -> bcd=20'h09999; bin0 changed after gnt -> result unchanged.
REQ-031 req1 asserted while busy -> no gnt until the first IDLE edge (E18); then gnt=10.
REQ-032 BCD_SIGNED_EN defined: bin0=16'h8000 -> sign=1, bcd=20'h32768; bin0=16'hFFFF -> sign=1, bcd=20'h00001.
